load_reg_bank: RTL and testbench
================================

# load_reg_bank

Parametrised bank of DEPTH double-buffered load registers, each WIDTH bits wide. Each channel has a shadow register written under one of four modes (load, shift-left, shift-right, increment) and an active register that updates only on a bank-wide commit strobe. All channels therefore switch together. The block sits between the bus/control FSM and downstream datapath configuration inputs that must never see partially updated settings.

## Interface
- WIDTH, 8, bits per channel (≥2)
- DEPTH, 4, number of channels (≥1, power of two not required)
- AW, $clog2(DEPTH) (min 1), address width, derived, not overridden
- RESET_VAL, 0, WIDTH-bit value loaded into every shadow and active register on reset/clear
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous clear of whole bank, highest synchronous priority
- load  in  1  operation strobe for channel addr
- addr  in  AW  target channel
- mode  in  2  0 = load value, 1 = shift left (ser_in into LSB), 2 = shift right (ser_in into MSB), 3 = increment
- value  in  WIDTH  data for mode 0
- ser_in  in  1  serial bit for modes 1/2
- commit  in  1  copy all shadows to active registers
- q  out  DEPTH*WIDTH  active registers, channel i at q[i*WIDTH +: WIDTH]
- pending  out  DEPTH  channel shadow written since last commit
- carry  out  1  one-cycle pulse: increment wrapped all-ones → 0
- addr_err  out  1  one-cycle pulse: load with addr ≥ DEPTH

## Operation
- reset: all shadows and q = RESET_VAL, pending = 0, carry = 0, addr_err = 0.
- Priority per edge: clear > (load, commit) > hold. Absent any of them, every register holds.
- clear: shadows and q = RESET_VAL, pending = 0. load/commit in the same cycle are ignored. carry and addr_err = 0.
- load with valid addr updates shadow[addr] by mode:
  - mode 0: shadow ← value.
  - mode 1: shadow ← {shadow[WIDTH-2:0], ser_in}.
  - mode 2: shadow ← {ser_in, shadow[WIDTH-1:1]}.
  - mode 3: shadow ← shadow + 1, modulo 2^WIDTH. carry pulses when the old shadow was all ones.
  - pending[addr] ← 1. Other channels are untouched.
- load with addr ≥ DEPTH: no register changes, addr_err pulses, pending unchanged.
- commit: for every channel, q[i] ← shadow[i]. pending ← all 0.
- load + commit in the same cycle: the commit uses the post-operation shadow. The addressed channel's new value is forwarded straight into q[addr]. pending[addr] ends 0.
- Serial/increment operations act on the shadow, never on q.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- Shadow update: visible in pending one cycle after the load edge. q changes only on the commit edge.
- Latency from load to q: 1 cycle if commit is asserted together with load, otherwise the cycle of the next commit.
- carry and addr_err are high for exactly the cycle after the triggering edge.
- Back-to-back loads to the same channel chain every cycle without stalls.
- Asynchronous reset mid-sequence discards all pending shadow data immediately.

## Structure
- Shared package load_reg_pkg:
  - mode constants MODE_LOAD = 2'd0, MODE_SHL = 2'd1, MODE_SHR = 2'd2, MODE_INC = 2'd3.
  - Channel-slice helper function.
- Sub-module load_reg_cell, generated DEPTH times. It holds one shadow, one active register and one pending bit, plus the mode mux. Its inputs are sel, op, commit and clear. Its outputs are q, pending and wrap.
- The top level contains:
  - address decode and range check
  - OR-reduction of the selected cell's wrap into carry
  - output flattening

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'h5A, assert reset → all q channels 8'h5A, pending=0. load ch2=8'h3C without commit → q unchanged, pending=4'b0100. Commit → q[2]=8'h3C, pending=0.
- Shift: ch1 shadow=8'h81. Mode 1 with ser_in=1 → 8'h03. Mode 2 with ser_in=0 → 8'h01. Commit → q[1]=8'h01.
- Increment wrap: ch0 shadow=8'hFF, mode 3 → shadow 8'h00 and carry high for one cycle. Second increment → 8'h01 with carry low.
- Load and commit together: load ch3=8'hA5 with commit high, ch0 shadow pending=8'h11 → next cycle q[3]=8'hA5, q[0]=8'h11, pending=0.
- Clear and invalid address:
  - DEPTH=3: load addr=3 → addr_err pulses, nothing changes.
  - clear asserted with load/commit → all RESET_VAL, pending=0.
  - Async reset between a load and its commit → load discarded.

Source files
------------

// File: rtl/load_reg_pkg.sv
// Shared definitions for the double-buffered load register bank:
// operation modes and the flattened-bus channel slice helper.
package load_reg_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_SHL  = 2'd1,
    MODE_SHR  = 2'd2,
    MODE_INC  = 2'd3
  } mode_e;

  // Low bit index of channel ch inside a flattened DEPTH*WIDTH bus.
  function automatic int unsigned chan_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/load_reg_cell.sv
// One channel of the bank: a shadow register written by the mode mux,
// and an active register that only takes the shadow on the bank-wide commit.
module load_reg_cell
  import load_reg_pkg::*;
#(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sel,
  input  mode_e            op,
  input  logic [WIDTH-1:0] value,
  input  logic             ser_in,
  input  logic             commit,
  output logic [WIDTH-1:0] q,
  output logic             pending,
  output logic             wrap
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;

  always_comb begin
    shadow_nxt = shadow;
    case (op)
      MODE_LOAD: shadow_nxt = value;
      MODE_SHL:  shadow_nxt = {shadow[WIDTH-2:0], ser_in};
      MODE_SHR:  shadow_nxt = {ser_in, shadow[WIDTH-1:1]};
      MODE_INC:  shadow_nxt = shadow + WIDTH'(1);
      default:   shadow_nxt = shadow;
    endcase
  end

  // Unregistered here; the top registers the OR of all cells into carry.
  assign wrap = sel && (op == MODE_INC) && (&shadow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= RESET_VAL;
      q       <= RESET_VAL;
      pending <= 1'b0;
    end else if (clear) begin
      shadow  <= RESET_VAL;
      q       <= RESET_VAL;
      pending <= 1'b0;
    end else begin
      if (sel)
        shadow <= shadow_nxt;
      // A same-cycle operation is forwarded so the commit sees the new shadow.
      if (commit) begin
        q       <= sel ? shadow_nxt : shadow;
        pending <= 1'b0;
      end else if (sel) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_reg_bank.sv
// Bank of DEPTH double-buffered load registers that all switch together on
// commit, so downstream configuration never sees a partial update.
module load_reg_bank
  import load_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic [AW-1:0]          addr,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       value,
  input  logic                   ser_in,
  input  logic                   commit,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic [DEPTH-1:0]       pending,
  output logic                   carry,
  output logic                   addr_err
);

  logic             in_range;
  logic [DEPTH-1:0] sel;
  logic [DEPTH-1:0] wrap;
  mode_e            op;

  // Extra bit keeps the compare correct when DEPTH == 2**AW.
  assign in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
  assign op       = mode_e'(mode);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ch
    assign sel[i] = load && in_range && (addr == AW'(i));

    load_reg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .sel     (sel[i]),
      .op      (op),
      .value   (value),
      .ser_in  (ser_in),
      .commit  (commit),
      .q       (q[chan_lo(i, WIDTH) +: WIDTH]),
      .pending (pending[i]),
      .wrap    (wrap[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry    <= 1'b0;
      addr_err <= 1'b0;
    end else if (clear) begin
      carry    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      carry    <= |wrap;
      addr_err <= load && !in_range;
    end
  end

endmodule

// File: tb/tb_load_reg_bank.sv
// Scoreboard bench: two banks (DEPTH 4 and 3) share stimulus; a reference
// model pushes expected outputs, a monitor pops and compares each cycle.
module tb_load_reg_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1, clear = 1'b0, load = 1'b0, ser_in = 1'b0, commit = 1'b0;
  logic [1:0] addr = '0, mode = '0;
  logic [7:0] value = '0;

  logic [31:0] q4;
  logic [23:0] q3;
  logic [3:0]  p4;
  logic [2:0]  p3;
  logic        c4, c3, e4, e3;

  always #5 clk = ~clk;

  load_reg_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .addr(addr), .mode(mode),
    .value(value), .ser_in(ser_in), .commit(commit), .q(q4), .pending(p4),
    .carry(c4), .addr_err(e4));

  load_reg_bank #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .addr(addr), .mode(mode),
    .value(value), .ser_in(ser_in), .commit(commit), .q(q3), .pending(p3),
    .carry(c3), .addr_err(e3));

  typedef struct packed {
    logic [31:0] q4;
    logic [23:0] q3;
    logic [3:0]  p4;
    logic [2:0]  p3;
    logic        c4, c3, e4, e3;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state, index 0 = DEPTH 4 bank, index 1 = DEPTH 3 bank.
  int dep[2] = '{4, 3};
  int m_sh[2][4];
  int m_q[2][4];
  bit m_pend[2][4];
  bit m_carry[2];
  bit m_err[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, cl, ld, input int a, m, v, input bit s, cm);
    for (int d = 0; d < 2; d++) begin
      m_carry[d] = 0;
      m_err[d]   = 0;
      if (r || cl) begin
        for (int i = 0; i < 4; i++) begin
          m_sh[d][i] = 'h5A; m_q[d][i] = 'h5A; m_pend[d][i] = 0;
        end
      end else begin
        if (ld) begin
          if (a >= dep[d]) m_err[d] = 1;
          else begin
            int old = m_sh[d][a];
            case (m)
              0: m_sh[d][a] = v;
              1: m_sh[d][a] = (old * 2 + s) % 256;
              2: m_sh[d][a] = old / 2 + s * 128;
              default: begin
                m_sh[d][a] = (old + 1) % 256;
                m_carry[d] = (old == 255);
              end
            endcase
            m_pend[d][a] = 1;
          end
        end
        if (cm)
          for (int i = 0; i < 4; i++) begin
            m_q[d][i] = m_sh[d][i]; m_pend[d][i] = 0;
          end
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.q4[i*8 +: 8] = 8'(m_q[0][i]);
      e.p4[i]        = m_pend[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      e.q3[i*8 +: 8] = 8'(m_q[1][i]);
      e.p3[i]        = m_pend[1][i];
    end
    e.c4 = m_carry[0]; e.c3 = m_carry[1];
    e.e4 = m_err[0];   e.e3 = m_err[1];
    return e;
  endfunction

  task automatic step(input bit r, cl, ld, input int a, m, v, input bit s, cm);
    bit was_reset;
    @(negedge clk);
    was_reset = reset;
    reset = r; clear = cl; load = ld; addr = 2'(a); mode = 2'(m);
    value = 8'(v); ser_in = s; commit = cm;
    model_step(r, cl, ld, a, m, v, s, cm);
    sb.push_back(model_out());
    if (r && !was_reset) begin
      // Asynchronous reset must act before the next clock edge.
      #1;
      check("async_rst_pend", {28'd0, p4}, 32'd0);
      check("async_rst_q",    q4, {4{8'h5A}});
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q_d4",       q4,               e.q4);
        check("q_d3",       {8'd0, q3},       {8'd0, e.q3});
        check("pending_d4", {28'd0, p4},      {28'd0, e.p4});
        check("pending_d3", {29'd0, p3},      {29'd0, e.p3});
        check("carry_d4",   {31'd0, c4},      {31'd0, e.c4});
        check("carry_d3",   {31'd0, c3},      {31'd0, e.c3});
        check("addr_err_d4",{31'd0, e4},      {31'd0, e.e4});
        check("addr_err_d3",{31'd0, e3},      {31'd0, e.e3});
      end
    end
  end

  initial begin : driver
    //   r  cl ld a  m  value  s  cm
    step(1, 0, 0, 0, 0, 'h00, 0, 0);
    step(1, 0, 0, 0, 0, 'h00, 0, 0);
    step(0, 0, 1, 2, 0, 'h3C, 0, 0);
    step(0, 0, 0, 0, 0, 'h00, 0, 0);
    step(0, 0, 0, 0, 0, 'h00, 0, 1);
    step(0, 0, 1, 1, 0, 'h81, 0, 0);
    step(0, 0, 1, 1, 1, 'h00, 1, 0);
    step(0, 0, 1, 1, 2, 'h00, 0, 0);
    step(0, 0, 0, 0, 0, 'h00, 0, 1);
    step(0, 0, 1, 0, 0, 'hFF, 0, 0);
    step(0, 0, 1, 0, 3, 'h00, 0, 0);
    step(0, 0, 1, 0, 3, 'h00, 0, 0);
    step(0, 0, 1, 0, 0, 'h11, 0, 0);
    step(0, 0, 1, 3, 0, 'hA5, 0, 1);
    step(0, 0, 1, 3, 0, 'hC3, 0, 0);
    step(0, 0, 1, 1, 0, 'h77, 0, 0);
    step(0, 1, 1, 1, 0, 'hEE, 0, 1);
    step(0, 0, 1, 2, 0, 'h99, 0, 0);
    step(1, 0, 0, 0, 0, 'h00, 0, 0);
    step(0, 0, 0, 0, 0, 'h00, 0, 1);
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 64) == 0, ($urandom % 32) == 0, ($urandom % 4) != 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), 1'($urandom), ($urandom % 5) == 0);
    end
    step(0, 0, 0, 0, 0, 'h00, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
